writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Final pipeline stage, directly downstream of the memory stage. Latches the
//  retiring instruction and drives the GPR write port and debug trace. Owns the
//  architectural HI/LO registers and feeds them back to execute for MFHI/MFLO.
//  Commits every instruction in exactly one cycle.
// PARAMETERS
//  RESET_PC    32'hbfc00000  value of the latched PC (and debug_wb_pc) after reset
//  HILO_RESET  32'h0         reset value of the HI and LO registers
// PORTS
//  clk               in   1   clock, rising edge
//  resetn            in   1   reset, synchronous, active-low
//  mem_to_wb_valid   in   1   memory stage offers an instruction
//  flush             in   1   exception/eret commit; kills the incoming instruction
//  wb_allowin        out  1   WB can accept this cycle
//  wb_valid          out  1   WB holds a valid instruction
//  mem_pc            in   32  PC of the offered instruction
//  mem_inst          in   32  instruction word
//  mem_rf_wdata      in   32  GPR write data
//  mem_rf_wen        in   4   GPR byte write enables
//  mem_rf_waddr      in   5   GPR destination
//  mem_op_HIWen      in   2   any bit set: write HI
//  mem_op_LOWen      in   2   any bit set: write LO
//  hi_in             in   32  new HI value
//  lo_in             in   32  new LO value
//  rf_we             out  4   GPR byte write enables to the register file
//  rf_waddr          out  5   GPR write address
//  rf_wdata          out  32  GPR write data
//  hi_out            out  32  HI value to execute (MFHI)
//  lo_out            out  32  LO value to execute (MFLO)
//  wb_pc             out  32  latched PC, for exception/EPC logic
//  debug_wb_pc       out  32  trace: retiring PC
//  debug_wb_rf_wen   out  4   trace: equals rf_we
//  debug_wb_rf_wnum  out  5   trace: equals rf_waddr
//  debug_wb_rf_wdata out  32  trace: equals rf_wdata
//  retire_cnt        out  32  number of retired instructions (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: wb_valid=0, pc=RESET_PC, inst/wdata/waddr/wen=0, HI=LO=HILO_RESET, retire_cnt=0.
//  - ready_go is always 1, so wb_allowin = !wb_valid | 1 = 1.
//  - Each edge: wb_valid <= mem_to_wb_valid & ~flush. The payload regs load only
//    when mem_to_wb_valid & ~flush. Otherwise the payload holds its old value.
//  - Latency: an instruction accepted at edge N drives rf_we in cycle N..N+1 and
//    updates HI/LO at edge N+1. Its residence in WB is exactly one cycle.
//  - rf_we = wb_valid ? wen_q : 4'h0. A write to rf_waddr=0 is passed through
//    unchanged, because the regfile ignores r0.
//  - HI update at an edge: wb_valid & |hiwen_q -> HI <= hi_q. LO is updated the
//    same way. An instruction with no enable bit set leaves HI/LO unchanged.
//    HI and LO may update in the same edge (MULT/DIV).
//  - hi_in/lo_in are captured into hi_q/lo_q at acceptance, together with the payload.
//  - flush with mem_to_wb_valid=1: the incoming instruction is dropped.
//    The instruction currently in WB still commits its GPR and HI/LO writes.
//  - resetn low while wb_valid=1: the pending HI/LO update is lost. State returns to reset values.
//  - Debug trace pins are combinational copies of the rf_* outputs plus pc_q.
//    debug_wb_rf_wen=0 whenever !wb_valid.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined:
//   - retire_cnt increments by 1 at every edge where wb_valid=1.
//   - It wraps from 32'hffffffff to 0 and is cleared by reset only.
//  WB_RETIRE_CNT_EN undefined:
//   - No counter flops exist and retire_cnt is tied to 32'h0.
// TESTING
//  1 Reset held 3 cycles -> wb_valid=0, rf_we=0, hi_out=lo_out=0, debug_wb_pc=32'hbfc00000.
//  2 Offer pc=32'hbfc00010, waddr=5, wdata=32'h12345678, wen=4'hf for one cycle
//    -> next cycle rf_we=4'hf, rf_waddr=5, debug_wb_pc=32'hbfc00010; cycle after, rf_we=0.
//  3 Offer HIWen=2'b01, LOWen=2'b01, hi_in=32'hdead0000, lo_in=32'h0000beef
//    -> two edges later hi_out=32'hdead0000, lo_out=32'h0000beef.
//  4 Offer an instruction with LOWen=2'b10 only -> LO updated; HI unchanged from the previous value.
//  5 Back-to-back offers A, B with flush=1 in B's acceptance cycle -> A commits, B never asserts rf_we, wb_valid=0.
//  6 (WB_RETIRE_CNT_EN) Retire 5 instructions, then preset the counter to 32'hfffffffe by force
//    and retire 3 more -> retire_cnt=5 after the first five, then 32'h1 after the three.

Source files
------------

// File: rtl/writeback_stage_if.sv
// Memory-to-writeback handshake and payload bus.
// The memory stage drives the master side; the writeback stage takes the slave side.
interface writeback_stage_if;
   logic        mem_to_wb_valid;
   logic        wb_allowin;
   logic [31:0] mem_pc;
   logic [31:0] mem_inst;
   logic [31:0] mem_rf_wdata;
   logic [3:0]  mem_rf_wen;
   logic [4:0]  mem_rf_waddr;
   logic [1:0]  mem_op_HIWen;
   logic [1:0]  mem_op_LOWen;
   logic [31:0] hi_in;
   logic [31:0] lo_in;

   modport master (
      output mem_to_wb_valid, mem_pc, mem_inst, mem_rf_wdata, mem_rf_wen,
             mem_rf_waddr, mem_op_HIWen, mem_op_LOWen, hi_in, lo_in,
      input  wb_allowin
   );

   modport slave (
      input  mem_to_wb_valid, mem_pc, mem_inst, mem_rf_wdata, mem_rf_wen,
             mem_rf_waddr, mem_op_HIWen, mem_op_LOWen, hi_in, lo_in,
      output wb_allowin
   );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: latches the retiring instruction, drives the GPR write port and trace,
// and owns architectural HI/LO. Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage #(
   parameter logic [31:0] RESET_PC   = 32'hbfc00000,
   parameter logic [31:0] HILO_RESET = 32'h0
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               flush,
   writeback_stage_if.slave   mem,
   output logic               wb_valid,
   output logic [3:0]         rf_we,
   output logic [4:0]         rf_waddr,
   output logic [31:0]        rf_wdata,
   output logic [31:0]        hi_out,
   output logic [31:0]        lo_out,
   output logic [31:0]        wb_pc,
   output logic [31:0]        debug_wb_pc,
   output logic [3:0]         debug_wb_rf_wen,
   output logic [4:0]         debug_wb_rf_wnum,
   output logic [31:0]        debug_wb_rf_wdata,
   output logic [31:0]        retire_cnt
);

   localparam logic READY_GO = 1'b1;

   logic        accept;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic [31:0] wdata_q;
   logic [4:0]  waddr_q;
   logic [3:0]  wen_q;
   logic [1:0]  hiwen_q;
   logic [1:0]  lowen_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] hi_r;
   logic [31:0] lo_r;

   assign mem.wb_allowin = !wb_valid || READY_GO;
   assign accept         = mem.mem_to_wb_valid && !flush;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wb_valid <= 1'b0;
         pc_q     <= RESET_PC;
         inst_q   <= 32'h0;
         wdata_q  <= 32'h0;
         waddr_q  <= 5'h0;
         wen_q    <= 4'h0;
         hiwen_q  <= 2'b00;
         lowen_q  <= 2'b00;
         hi_q     <= 32'h0;
         lo_q     <= 32'h0;
         hi_r     <= HILO_RESET;
         lo_r     <= HILO_RESET;
      end else begin
         wb_valid <= accept;
         if (accept) begin
            pc_q    <= mem.mem_pc;
            inst_q  <= mem.mem_inst;
            wdata_q <= mem.mem_rf_wdata;
            waddr_q <= mem.mem_rf_waddr;
            wen_q   <= mem.mem_rf_wen;
            hiwen_q <= mem.mem_op_HIWen;
            lowen_q <= mem.mem_op_LOWen;
            hi_q    <= mem.hi_in;
            lo_q    <= mem.lo_in;
         end
         // The instruction already in WB commits HI/LO even if the incoming one is flushed.
         if (wb_valid && |hiwen_q) hi_r <= hi_q;
         if (wb_valid && |lowen_q) lo_r <= lo_q;
      end
   end

   // Instruction word is held for debug visibility only; nothing downstream consumes it.
   logic unused_inst;
   assign unused_inst = ^inst_q;

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= 32'h0;
      end else if (wb_valid) begin
         cnt_q <= cnt_q + 32'h1;
      end
   end

   assign retire_cnt = cnt_q;
`else
   assign retire_cnt = 32'h0;
`endif

   assign rf_we    = wb_valid ? wen_q : 4'h0;
   assign rf_waddr = waddr_q;
   assign rf_wdata = wdata_q;
   assign hi_out   = hi_r;
   assign lo_out   = lo_r;
   assign wb_pc    = pc_q;

   assign debug_wb_pc       = pc_q;
   assign debug_wb_rf_wen   = rf_we;
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the retiring instruction and HI/LO.
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        flush = 1'b0;
   logic        wb_valid;
   logic [3:0]  rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic [31:0] wb_pc;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;
   logic [31:0] retire_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   writeback_stage_if bus ();

   writeback_stage dut (
      .clk               (clk),
      .resetn            (resetn),
      .flush             (flush),
      .mem               (bus.slave),
      .wb_valid          (wb_valid),
      .rf_we             (rf_we),
      .rf_waddr          (rf_waddr),
      .rf_wdata          (rf_wdata),
      .hi_out            (hi_out),
      .lo_out            (lo_out),
      .wb_pc             (wb_pc),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata),
      .retire_cnt        (retire_cnt)
   );

   // Reference: the one instruction resident in WB, plus architectural HI/LO and retire count.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] wdata;
      logic [4:0]  waddr;
      logic [3:0]  wen;
      logic [1:0]  hiwen;
      logic [1:0]  lowen;
      logic [31:0] hi;
      logic [31:0] lo;
   } instr_t;

   logic        m_valid;
   instr_t      m_ins;
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic [31:0] m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_ins   = '{pc: 32'hbfc00000, wdata: 32'h0, waddr: 5'h0, wen: 4'h0,
                  hiwen: 2'b00, lowen: 2'b00, hi: 32'h0, lo: 32'h0};
      m_hi    = 32'h0;
      m_lo    = 32'h0;
      m_cnt   = 32'h0;
   endtask

   task automatic check_all();
      chk("wb_valid",    32'(wb_valid),          32'(m_valid));
      chk("wb_allowin",  32'(bus.wb_allowin),    32'h1);
      chk("rf_we",       32'(rf_we),             m_valid ? 32'(m_ins.wen) : 32'h0);
      chk("rf_waddr",    32'(rf_waddr),          32'(m_ins.waddr));
      chk("rf_wdata",    rf_wdata,               m_ins.wdata);
      chk("hi_out",      hi_out,                 m_hi);
      chk("lo_out",      lo_out,                 m_lo);
      chk("wb_pc",       wb_pc,                  m_ins.pc);
      chk("dbg_pc",      debug_wb_pc,            m_ins.pc);
      chk("dbg_wen",     32'(debug_wb_rf_wen),   m_valid ? 32'(m_ins.wen) : 32'h0);
      chk("dbg_wnum",    32'(debug_wb_rf_wnum),  32'(m_ins.waddr));
      chk("dbg_wdata",   debug_wb_rf_wdata,      m_ins.wdata);
`ifdef WB_RETIRE_CNT_EN
      chk("retire_cnt",  retire_cnt,             m_cnt);
`else
      chk("retire_cnt",  retire_cnt,             32'h0);
`endif
   endtask

   // One clock: drive inputs at negedge, advance the model at posedge, check just after.
   task automatic step(input logic rst_n, input logic v, input logic fl, input instr_t ins);
      @(negedge clk);
      resetn                 = rst_n;
      flush                  = fl;
      bus.mem_to_wb_valid    = v;
      bus.mem_pc             = ins.pc;
      bus.mem_inst           = $urandom;
      bus.mem_rf_wdata       = ins.wdata;
      bus.mem_rf_wen         = ins.wen;
      bus.mem_rf_waddr       = ins.waddr;
      bus.mem_op_HIWen       = ins.hiwen;
      bus.mem_op_LOWen       = ins.lowen;
      bus.hi_in              = ins.hi;
      bus.lo_in              = ins.lo;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         if (m_valid && m_ins.hiwen != 2'b00) m_hi = m_ins.hi;
         if (m_valid && m_ins.lowen != 2'b00) m_lo = m_ins.lo;
         if (m_valid) m_cnt = m_cnt + 32'h1;
         m_valid = v && !fl;
         if (m_valid) m_ins = ins;
      end
      #1;
      check_all();
   endtask

   function automatic instr_t rand_ins();
      instr_t r;
      r.pc    = {$urandom} & 32'hffff_fffc;
      r.wdata = $urandom;
      r.waddr = 5'($urandom);
      r.wen   = 4'($urandom);
      r.hiwen = 2'($urandom);
      r.lowen = 2'($urandom);
      r.hi    = $urandom;
      r.lo    = $urandom;
      return r;
   endfunction

   function automatic instr_t mk(input logic [31:0] pc, input logic [31:0] wdata,
                                 input logic [4:0] waddr, input logic [3:0] wen,
                                 input logic [1:0] hiwen, input logic [1:0] lowen,
                                 input logic [31:0] hi, input logic [31:0] lo);
      instr_t r;
      r = '{pc: pc, wdata: wdata, waddr: waddr, wen: wen,
            hiwen: hiwen, lowen: lowen, hi: hi, lo: lo};
      return r;
   endfunction

   instr_t idle;

   initial begin
      model_reset();
      idle = mk(32'h0, 32'h0, 5'h0, 4'h0, 2'b00, 2'b00, 32'h0, 32'h0);

      // Reset held three cycles
      repeat (3) step(1'b0, 1'b0, 1'b0, idle);
      chk("t1_rf_we",  32'(rf_we), 32'h0);
      chk("t1_hi",     hi_out,     32'h0);
      chk("t1_lo",     lo_out,     32'h0);
      chk("t1_dbg_pc", debug_wb_pc, 32'hbfc00000);

      // Single GPR write
      step(1'b1, 1'b1, 1'b0, mk(32'hbfc00010, 32'h12345678, 5'd5, 4'hf, 2'b00, 2'b00, 32'h0, 32'h0));
      chk("t2_rf_we",    32'(rf_we),    32'hf);
      chk("t2_rf_waddr", 32'(rf_waddr), 32'd5);
      chk("t2_dbg_pc",   debug_wb_pc,   32'hbfc00010);
      step(1'b1, 1'b0, 1'b0, idle);
      chk("t2_rf_we_off", 32'(rf_we), 32'h0);

      // HI and LO in the same commit
      step(1'b1, 1'b1, 1'b0, mk(32'hbfc00014, 32'h0, 5'd0, 4'h0, 2'b01, 2'b01, 32'hdead0000, 32'h0000beef));
      step(1'b1, 1'b0, 1'b0, idle);
      chk("t3_hi", hi_out, 32'hdead0000);
      chk("t3_lo", lo_out, 32'h0000beef);

      // LO only; HI keeps its earlier value
      step(1'b1, 1'b1, 1'b0, mk(32'hbfc00018, 32'h0, 5'd0, 4'h0, 2'b00, 2'b10, 32'h99999999, 32'h11112222));
      step(1'b1, 1'b0, 1'b0, idle);
      chk("t4_lo", lo_out, 32'h11112222);
      chk("t4_hi", hi_out, 32'hdead0000);

      // A then flushed B: A still commits GPR and HI
      step(1'b1, 1'b1, 1'b0, mk(32'hbfc00020, 32'haaaa5555, 5'd7, 4'h3, 2'b11, 2'b00, 32'hcafef00d, 32'h0));
      chk("t5_a_rf_we", 32'(rf_we), 32'h3);
      step(1'b1, 1'b1, 1'b1, mk(32'hbfc00024, 32'h5555aaaa, 5'd8, 4'hf, 2'b00, 2'b11, 32'h0, 32'h77777777));
      chk("t5_b_valid", 32'(wb_valid), 32'h0);
      chk("t5_b_rf_we", 32'(rf_we),    32'h0);
      chk("t5_a_hi",    hi_out,        32'hcafef00d);
      chk("t5_b_lo",    lo_out,        32'h11112222);
      step(1'b1, 1'b0, 1'b0, idle);

      // Reset while an instruction with a HI/LO update is resident: the update is lost
      step(1'b1, 1'b1, 1'b0, mk(32'hbfc00030, 32'h1, 5'd1, 4'h1, 2'b01, 2'b01, 32'h12121212, 32'h34343434));
      step(1'b0, 1'b0, 1'b0, idle);
      chk("rst_hi_lost", hi_out, 32'h0);
      chk("rst_lo_lost", lo_out, 32'h0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic rst_n, v, fl;
         rst_n = ($urandom_range(0, 31) != 0);
         v     = ($urandom_range(0, 3) != 0);
         fl    = ($urandom_range(0, 5) == 0);
         step(rst_n, v, fl, rand_ins());
      end

`ifdef WB_RETIRE_CNT_EN
      step(1'b0, 1'b0, 1'b0, idle);
      repeat (5) step(1'b1, 1'b1, 1'b0, rand_ins());
      step(1'b1, 1'b0, 1'b0, idle);
      chk("t6_cnt5", retire_cnt, 32'd5);
      force dut.cnt_q = 32'hfffffffe;
      m_cnt = 32'hfffffffe;
      step(1'b1, 1'b0, 1'b0, idle);
      release dut.cnt_q;
      repeat (3) step(1'b1, 1'b1, 1'b0, rand_ins());
      step(1'b1, 1'b0, 1'b0, idle);
      chk("t6_wrap", retire_cnt, 32'h1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
